// File: rtl/tt_sweep_checker.sv
// Sweeps {a,b,c} through 000..111, samples y_in after a settle delay per vector,
// and scores the captured truth table against EXPECTED.
module tt_sweep_checker #(
  parameter logic [7:0] EXPECTED = 8'hB0,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out,
  output logic [3:0] mism_count,
  output logic [2:0] first_fail
);

  if (SETTLE < 1 || SETTLE > 15) begin : gBadSettle
    $error("tt_sweep_checker: SETTLE must be in 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state, stateNxt;
  logic [2:0] index, indexNxt;
  logic [3:0] settleCnt, settleCntNxt;
  logic [7:0] tableReg, tableNxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= 3'd0;
      settleCnt <= 4'd0;
      tableReg  <= 8'd0;
    end else begin
      state     <= stateNxt;
      index     <= indexNxt;
      settleCnt <= settleCntNxt;
      tableReg  <= tableNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    indexNxt     = index;
    settleCntNxt = settleCnt;
    tableNxt     = tableReg;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNxt     = DRIVE;
          indexNxt     = 3'd0;
          settleCntNxt = 4'd0;
          tableNxt     = 8'd0;
        end
      end
      DRIVE: begin
        settleCntNxt = settleCnt + 4'd1;
        if (settleCnt == LAST_CNT) stateNxt = SAMPLE;
      end
      SAMPLE: begin
        // Vector only advances on the edge that captures its result.
        tableNxt[index] = y_in;
        if (index == 3'd7) begin
          stateNxt = DONE;
        end else begin
          indexNxt     = index + 3'd1;
          settleCntNxt = 4'd0;
          stateNxt     = DRIVE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign {a_out, b_out, c_out} = index;
  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign done      = (state == DONE);
  assign table_out = tableReg;

  logic [7:0] diff;
  logic [3:0] popCnt;
  logic [2:0] lowIdx;

  assign diff = tableReg ^ EXPECTED;

  always_comb begin
    popCnt = 4'd0;
    lowIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      popCnt = popCnt + {3'd0, diff[i]};
      if (diff[i]) lowIdx = 3'(i);
    end
  end

  // Scores are meaningful only once the full table is in.
  assign pass       = done && (diff == 8'd0);
  assign mism_count = done ? popCnt : 4'd0;
  assign first_fail = done ? lowIdx : 3'd0;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: three checker instances (SETTLE 2, 5, 3), the last two
// driven through a 4-cycle delayed copy of the reference function.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] startV = 3'b000;
  logic [1:0] yMode = 2'd0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic refF(input logic a, input logic b, input logic c);
    return a & (~b | c);
  endfunction

  logic [2:0] aV, bV, cV, busyV, doneV, passV, yV;
  logic [7:0] tblV [3];
  logic [3:0] mismV [3];
  logic [2:0] ffV [3];
  logic [3:0] dly1, dly2;

  always_comb begin
    case (yMode)
      2'd0:    yV[0] = refF(aV[0], bV[0], cV[0]);
      2'd1:    yV[0] = 1'b0;
      2'd2:    yV[0] = aV[0];
      default: yV[0] = 1'b1;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      dly1 <= 4'd0;
      dly2 <= 4'd0;
    end else begin
      dly1 <= {dly1[2:0], refF(aV[1], bV[1], cV[1])};
      dly2 <= {dly2[2:0], refF(aV[2], bV[2], cV[2])};
    end
  end
  assign yV[1] = dly1[3];
  assign yV[2] = dly2[3];

  tt_sweep_checker #(.EXPECTED(8'hB0), .SETTLE(2)) u0 (
    .clk(clk), .reset(reset), .start(startV[0]), .y_in(yV[0]),
    .a_out(aV[0]), .b_out(bV[0]), .c_out(cV[0]), .busy(busyV[0]), .done(doneV[0]),
    .pass(passV[0]), .table_out(tblV[0]), .mism_count(mismV[0]), .first_fail(ffV[0]));

  tt_sweep_checker #(.EXPECTED(8'hB0), .SETTLE(5)) u1 (
    .clk(clk), .reset(reset), .start(startV[1]), .y_in(yV[1]),
    .a_out(aV[1]), .b_out(bV[1]), .c_out(cV[1]), .busy(busyV[1]), .done(doneV[1]),
    .pass(passV[1]), .table_out(tblV[1]), .mism_count(mismV[1]), .first_fail(ffV[1]));

  tt_sweep_checker #(.EXPECTED(8'hB0), .SETTLE(3)) u2 (
    .clk(clk), .reset(reset), .start(startV[2]), .y_in(yV[2]),
    .a_out(aV[2]), .b_out(bV[2]), .c_out(cV[2]), .busy(busyV[2]), .done(doneV[2]),
    .pass(passV[2]), .table_out(tblV[2]), .mism_count(mismV[2]), .first_fail(ffV[2]));

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chkIdle0(input string tag);
    chk({tag, ".busy"}, busyV[0], 0);
    chk({tag, ".done"}, doneV[0], 0);
    chk({tag, ".pass"}, passV[0], 0);
    chk({tag, ".tbl"},  tblV[0], 0);
    chk({tag, ".mism"}, mismV[0], 0);
    chk({tag, ".ff"},   ffV[0], 0);
    chk({tag, ".abc"},  {aV[0], bV[0], cV[0]}, 0);
  endtask

  // One start pulse, then count edges to done and score the final table.
  task automatic runSweep(input string tag, input int sel, input int expEdges, input bit poke,
                          input logic [7:0] expTbl, input bit expPass, input int expMism,
                          input int expFf);
    int n;
    @(negedge clk); startV[sel] = 1'b1;
    @(posedge clk); #1; startV[sel] = 1'b0;
    chk({tag, ".doneDrop"}, doneV[sel], 0);
    chk({tag, ".busyRise"}, busyV[sel], 1);
    n = 0;
    while (!doneV[sel] && n < 200) begin
      @(negedge clk);
      startV[sel] = poke ? n[0] : 1'b0;
      if (n == 10) begin
        chk({tag, ".gatedMism"}, (sel == 0) ? mismV[0] : (sel == 1) ? mismV[1] : mismV[2], 0);
        chk({tag, ".gatedPass"}, passV[sel], 0);
      end
      @(posedge clk); #1;
      n++;
      if (!doneV[sel] && busyV[sel] !== 1'b1) chk({tag, ".busy"}, busyV[sel], 1);
    end
    startV[sel] = 1'b0;
    chk({tag, ".edges"}, n, expEdges);
    chk({tag, ".busyEnd"}, busyV[sel], 0);
    chk({tag, ".tbl"},  tblV[sel], expTbl);
    chk({tag, ".pass"}, passV[sel], expPass);
    chk({tag, ".mism"}, mismV[sel], expMism);
    chk({tag, ".ff"},   ffV[sel], expFf);
    repeat (3) @(posedge clk);
    #1 chk({tag, ".doneHold"}, doneV[sel], 1);
    chk({tag, ".tblHold"}, tblV[sel], expTbl);
  endtask

  initial begin
    int k;
    #12 chkIdle0("reset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);

    yMode = 2'd0; runSweep("ref",  0, 24, 1'b0, 8'hB0, 1'b1, 0, 0);
    yMode = 2'd1; runSweep("zero", 0, 24, 1'b0, 8'h00, 1'b0, 3, 4);
    yMode = 2'd2; runSweep("yEqA", 0, 24, 1'b0, 8'hF0, 1'b0, 1, 6);
    yMode = 2'd0; runSweep("poke", 0, 24, 1'b1, 8'hB0, 1'b1, 0, 0);

    // Asynchronous reset while vector 3 is being held.
    yMode = 2'd3;
    @(negedge clk); startV[0] = 1'b1;
    @(posedge clk); #1; startV[0] = 1'b0;
    k = 0;
    while ({aV[0], bV[0], cV[0]} != 3'd3 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("rstMid.reachIdx3", {aV[0], bV[0], cV[0]}, 3);
    chk("rstMid.partialTbl", tblV[0], 8'h07);
    @(negedge clk); #2 reset = 1'b1;
    #1 chkIdle0("rstMid");
    @(negedge clk); reset = 1'b0;
    yMode = 2'd0; runSweep("afterRst", 0, 24, 1'b0, 8'hB0, 1'b1, 0, 0);

    runSweep("settle5", 1, 48, 1'b0, 8'hB0, 1'b1, 0, 0);
    runSweep("settle3", 2, 32, 1'b0, 8'h60, 1'b0, 3, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Stimulus-and-capture stage for the lab's 3-input combinational functions (SOP, POS and minimized variants of Y = A(B'+C)).
- Drives A,B,C through all 8 combinations (000..111), waits a settle time, samples the function's Y, and assembles the observed truth table.
- Compares the observed table against an expected table and reports pass, mismatch count and first failing index.
- Sits directly upstream of the function under test on a,b,c, and downstream of it on y_in.

Parameters:
- EXPECTED, 8'hB0, expected truth table; bit i = Y for {A,B,C}=i (0xB0 = minterms 4,5,7).
- SETTLE, 2, cycles {a,b,c} is held before sampling y_in; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE and DONE
- y_in  input  1  Y output of the function under test
- a_out  output  1  stimulus A (MSB of vector index)
- b_out  output  1  stimulus B
- c_out  output  1  stimulus C (LSB)
- busy  output  1  high in DRIVE and SAMPLE
- done  output  1  high in DONE
- pass  output  1  table_out == EXPECTED; valid only while done=1, else 0
- table_out  output  8  observed truth table
- mism_count  output  4  popcount(table_out ^ EXPECTED), range 0..8
- first_fail  output  3  lowest index i where table_out[i] != EXPECTED[i]; 0 when pass=1

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE; index=0; settle counter=0; table_out=0; a/b/c=0; busy=0; done=0; pass=0; mism_count=0; first_fail=0.
- Stimulus outputs are registered: {a_out,b_out,c_out} = index[2:0] at all times.
- IDLE:
  - start=1 at a rising edge: clear table_out, mism_count and first_fail; set index=0 and settle counter=0; go to DRIVE.
- DRIVE:
  - Hold the vector. Increment the settle counter each cycle.
  - After SETTLE cycles in DRIVE, go to SAMPLE.
  - start is ignored.
- SAMPLE (exactly 1 cycle):
  - At the edge leaving SAMPLE, set table_out[index] = y_in.
  - If index==7: go to DONE.
  - Else: index = index+1, settle counter = 0, go to DRIVE.
  - start is ignored.
- DONE:
  - done=1. pass, mism_count and first_fail are computed from the final table_out and held stable.
  - start=1 restarts exactly as from IDLE: done drops and busy rises on the same edge.
  - The block otherwise stays in DONE indefinitely. It never returns to IDLE except via reset.
- Timing:
  - With start accepted at edge e0, each vector takes SETTLE+1 cycles.
  - done rises at edge e0 + 8*(SETTLE+1). For SETTLE=2 that is e0+24.
- Sample point: y_in is sampled on the last cycle a vector is held. The vector never changes in the same cycle it is sampled.
- Index wrap: index never wraps during a sweep. After index 7, the index stays at 7 in DONE until a restart.
- Reset mid-sweep: everything returns to reset values immediately (asynchronous). No partial table is retained.
- table_out bits for indices not yet sampled read 0 while busy.
- mism_count and first_fail are combinational from table_out. They are gated to 0 unless done=1.
- SETTLE outside 1..15: elaboration-time error.

Test Plan:
- Reference model y_in = a&(~b|c), SETTLE=2, one start pulse -> table_out=8'hB0, pass=1, mism_count=0, done rises exactly 24 edges after the start edge, busy=1 throughout.
- y_in tied 0 -> table_out=8'h00, pass=0, mism_count=3, first_fail=4.
- y_in = a (bug, ignores b/c) -> table_out=8'hF0, pass=0, mism_count=1, first_fail=6.
- start pulsed repeatedly during the sweep -> no effect on timing or table; start in DONE -> new sweep, done drops on that edge, identical results.
- reset asserted asynchronously at mid-vector index 3 -> all outputs 0 immediately, state IDLE; a subsequent start gives a full clean sweep.
- SETTLE=5 with y_in delayed 4 cycles from a/b/c -> table_out=8'hB0, pass=1, done at start edge +48; with SETTLE=3 and the same delay -> mismatches reported.
